seq_shift_add_multiplier: RTL and testbench
===========================================

# seq_shift_add_multiplier

Parametrised sequential unsigned multiplier computing Y = A × B by shift-and-add, one multiplier bit per clock. It is the clocked, width-generic successor of the fixed 4×3 combinational multiplier. It adds a start/busy/done handshake and registered operands and result, so wide products do not create a long combinational path. It sits between an operand source (register file or test sequencer) and any consumer that samples Y on done.

## Interface
- WA, default 4: width of multiplicand A; must be ≥1.
- WB, default 3: width of multiplier B, which also sets the iteration count; must be ≥1.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request; sampled only when the block is ready (state IDLE or DONE).
- A  in  WA  multiplicand, unsigned; sampled on the accepting edge only.
- B  in  WB  multiplier, unsigned; sampled on the accepting edge only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse, high in DONE; Y is valid while done is high.
- Y  out  WA+WB  registered unsigned product; holds its value until the next completion.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- Internal registers:
  - mcand, WA+WB bits: A zero-extended.
  - mplr, WB bits.
  - acc, WA+WB bits.
  - cnt, $clog2(WB+1) bits.
- IDLE or DONE with start=1: mcand ← A zero-extended, mplr ← B, acc ← 0, cnt ← 0, go to RUN.
- IDLE with start=0: stay. DONE with start=0: go to IDLE.
- RUN, each edge, one iteration:
  - If mplr[0]=1, acc ← acc + mcand.
  - mcand ← mcand << 1; mplr ← mplr >> 1; cnt ← cnt + 1.
  - When cnt = WB−1, i.e. the last iteration: Y ← final acc value including this iteration's add; go to DONE.
- start is ignored while in RUN. A and B may change freely after the accepting edge.
- Arithmetic:
  - acc and mcand are WA+WB bits wide; no overflow is possible.
  - Y equals A×B exactly for all inputs, including A=0, B=0 and all-ones.
- Reset: rst_n=0 at any edge, including mid-RUN, forces:
  - state = IDLE
  - busy = 0, done = 0, Y = 0
  - acc, mcand, mplr, cnt = 0
  - The operation in progress is discarded; no done pulse is produced.

## Timing
- Accepting edge E0. RUN covers the cycles after edges E0 … E0+WB−1.
- Edge E0+WB: Y is updated and done goes high for exactly one cycle.
- Latency from start sampled to done high: WB+1 cycles. With the defaults, done is high in the 4th cycle after the accepting edge.
- busy is high for exactly WB cycles per operation. busy and done are never high together.
- Back-to-back: start held high during DONE is accepted on the edge leaving DONE. Sustained throughput is one product per WB+1 cycles; done pulses are separated by WB cycles low.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SEQ_MULT_EARLY_TERM_EN:
  - Defined: in RUN, the block also goes to DONE, loading Y, when the post-shift value of mplr is 0. Latency becomes (index of the highest set bit of B)+2 cycles, and 2 cycles when B=0. Y is unchanged.
  - Undefined: fixed WB iterations and latency WB+1 regardless of operand values.
  - Either way, busy is high only in RUN and done is still a single-cycle pulse.

## Test plan
- Defaults, A=5 B=3 → done pulse WB+1=4 cycles after accept, Y=15. A=15 B=5 → Y=75. A=3 B=6 → Y=18. A=15 B=7 → Y=105. Each check: busy high for exactly 3 cycles.
- Zero operands, defaults: A=0 B=7 → Y=0; A=9 B=0 → Y=0. With SEQ_MULT_EARLY_TERM_EN defined, B=0 → done 2 cycles after accept; B=3 → done 3 cycles after accept.
- Start while busy: accept 5×3, then pulse start with A=15 B=7 during RUN → ignored; Y=15, single done pulse.
- Back-to-back: start held high across two operations (5×3, then 3×6) → done pulses 4 cycles apart, Y=15 then 18.
- Reset mid-RUN: accept 15×7, drop rst_n for one edge in the 2nd RUN cycle → busy=0, done=0, Y=0 next cycle, no done afterward. A new 3×6 then gives Y=18.
- Parameter variant WA=8 WB=8: 255×255 → Y=65025 after 9 cycles; 128×2 → Y=256.

Source files
------------

// File: rtl/seq_shift_add_multiplier_if.sv
// Handshake/operand bus for seq_shift_add_multiplier.
// The master side drives start, A and B. The slave side (the multiplier)
// returns busy, done and the product Y.
interface seq_shift_add_multiplier_if #(
  parameter int WA = 4,
  parameter int WB = 3
);
  logic             start;
  logic [WA-1:0]    A;
  logic [WB-1:0]    B;
  logic             busy;
  logic             done;
  logic [WA+WB-1:0] Y;

  modport master (output start, A, B, input  busy, done, Y);
  modport slave  (input  start, A, B, output busy, done, Y);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, Y = A * B.
// It retires one multiplier bit per clock and registers both operands and
// the result.
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN. When it is defined, the
// block finishes as soon as no set multiplier bits remain.
module seq_shift_add_multiplier #(
  parameter int WA = 4,
  parameter int WB = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  seq_shift_add_multiplier_if.slave bus
);
  localparam int WP = WA + WB;
  localparam int CW = (WB < 1) ? 1 : $clog2(WB + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [WP-1:0] mcand, acc, acc_nxt, y_q;
  logic [WB-1:0] mplr;
  logic [CW-1:0] cnt;
  logic          last, accept;

  // Accumulator value after this cycle's conditional add.
  // Last-iteration detect: either the bit count is used up, or, with early
  // termination, no set multiplier bits remain after the shift.
  always_comb begin
    acc_nxt = acc + (mplr[0] ? mcand : '0);
`ifdef SEQ_MULT_EARLY_TERM_EN
    last    = (cnt == CW'(WB - 1)) || ((mplr >> 1) == '0);
`else
    last    = (cnt == CW'(WB - 1));
`endif
    accept  = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. start is looked at only in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load the operands on accept, then run one shift-add per RUN
  // cycle. The product is latched on the last iteration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      y_q   <= '0;
    end else if (accept) begin
      mcand <= WP'(bus.A);
      mplr  <= bus.B;
      acc   <= '0;
      cnt   <= '0;
    end else if (state_q == RUN) begin
      acc   <= acc_nxt;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 1'b1;
      if (last) y_q <= acc_nxt;
    end
  end

  // The outputs are decoded straight from registers, so no input reaches
  // an output through combinational logic.
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.Y    = y_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier. It drives a default
// 4x3 instance and an 8x8 instance, and checks products and timing against
// plain integer arithmetic.
module tb_seq_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_shift_add_multiplier_if #(.WA(4), .WB(3)) b4 ();
  seq_shift_add_multiplier_if #(.WA(8), .WB(8)) b8 ();

  seq_shift_add_multiplier #(.WA(4), .WB(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  seq_shift_add_multiplier #(.WA(8), .WB(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected cycles from the accepting edge until done goes high.
  function automatic int exp_lat(input longint b, input int wb);
`ifdef SEQ_MULT_EARLY_TERM_EN
    if (b == 0) return 2;
    return $clog2(b + 1) + 1;
`else
    return wb + 1;
`endif
  endfunction

  task automatic drive(input bit sel, input logic st, input longint a, input longint b);
    if (sel) begin b8.start = st; b8.A = a[7:0]; b8.B = b[7:0]; end
    else     begin b4.start = st; b4.A = a[3:0]; b4.B = b[2:0]; end
  endtask

  task automatic sample(input bit sel, output logic bs, output logic dn, output logic [63:0] y);
    if (sel) begin bs = b8.busy; dn = b8.done; y = 64'(b8.Y); end
    else     begin bs = b4.busy; dn = b4.done; y = 64'(b4.Y); end
  endtask

  // One full operation on the selected instance. It checks the product, the
  // latency, the number of busy cycles, and that busy and done never overlap.
  task automatic op(input bit sel, input longint a, input longint b, input string tag);
    int wb = sel ? 8 : 3;
    int lat = 0, nbusy = 0, ovl = 0;
    logic bs, dn;
    logic [63:0] y, yv = '0;
    @(negedge clk); drive(sel, 1'b1, a, b);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) drive(sel, 1'b0, longint'($urandom), longint'($urandom));
      sample(sel, bs, dn, y);
      if (bs) nbusy++;
      if (bs && dn) ovl++;
      if (dn) begin lat = n; yv = y; break; end
    end
    check({tag, "_y"},    yv, 64'(a * b));
    check({tag, "_lat"},  64'(lat), 64'(exp_lat(b, wb)));
    check({tag, "_busy"}, 64'(nbusy), 64'(exp_lat(b, wb) - 1));
    check({tag, "_ovl"},  64'(ovl), 64'd0);
  endtask

  initial begin
    int nd, t1, t2;
    logic [63:0] y1, y2;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst4_busy", 64'(b4.busy), 0);
    check("rst4_done", 64'(b4.done), 0);
    check("rst4_y",    64'(b4.Y), 0);
    check("rst8_y",    64'(b8.Y), 0);
    rst_n = 1'b1;

    // Directed products.
    op(1'b0, 5, 3, "d5x3");
    op(1'b0, 15, 5, "d15x5");
    op(1'b0, 3, 6, "d3x6");
    op(1'b0, 15, 7, "d15x7");
    op(1'b0, 0, 7, "d0x7");
    op(1'b0, 9, 0, "d9x0");
    op(1'b1, 255, 255, "w255x255");
    op(1'b1, 128, 2, "w128x2");
    op(1'b1, 0, 0, "w0x0");

    // Random products.
    for (int i = 0; i < 25; i++)
      op(1'b0, longint'($urandom_range(0, 15)), longint'($urandom_range(0, 7)), "r4");
    for (int i = 0; i < 15; i++)
      op(1'b1, longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)), "r8");

    // A start pulse during RUN must be ignored.
    @(negedge clk); drive(1'b0, 1'b1, 5, 3);
    nd = 0; y1 = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) drive(1'b0, 1'b0, 0, 0);
      if (n == 2) drive(1'b0, 1'b1, 15, 7);
      if (n == 3) drive(1'b0, 1'b0, 0, 0);
      if (b4.done) begin nd++; y1 = 64'(b4.Y); end
    end
    check("busy_start_y",     y1, 64'd15);
    check("busy_start_ndone", 64'(nd), 64'd1);
    check("busy_start_hold",  64'(b4.Y), 64'd15);

    // Back-to-back: start stays high across two operations.
    @(negedge clk); drive(1'b0, 1'b1, 5, 3);
    t1 = 0; t2 = 0; y1 = '0; y2 = '0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (b4.done) begin
        if (t1 == 0) begin t1 = n; y1 = 64'(b4.Y); b4.A = 4'd3; b4.B = 3'd6; end
        else begin t2 = n; y2 = 64'(b4.Y); break; end
      end else if (t1 != 0 && n == t1 + 1) b4.start = 1'b0;
    end
    b4.start = 1'b0;
    check("b2b_y1",  y1, 64'd15);
    check("b2b_y2",  y2, 64'd18);
    check("b2b_t1",  64'(t1), 64'(exp_lat(3, 3)));
    check("b2b_gap", 64'(t2 - t1), 64'(exp_lat(6, 3)));

    // Reset in the middle of RUN discards the operation.
    @(negedge clk); drive(1'b0, 1'b1, 15, 7);
    @(negedge clk); drive(1'b0, 1'b0, 0, 0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("mrst_busy", 64'(b4.busy), 0);
    check("mrst_done", 64'(b4.done), 0);
    check("mrst_y",    64'(b4.Y), 0);
    nd = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (b4.done) nd++;
    end
    check("mrst_nodone", 64'(nd), 0);
    op(1'b0, 3, 6, "mrst_3x6");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
